// File: rtl/shared_reg_arbiter_pkg.sv
// rtl/shared_reg_arbiter_pkg.sv - shared types and helpers for the shared register arbiter
package shared_reg_pkg;

    // Largest supported requester count and the index width it needs.
    localparam int N_MAX     = 16;
    localparam int IDX_MAX_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // One-hot decode sized for N_MAX; callers keep the low N bits.
    function automatic logic [N_MAX-1:0] onehot(input logic [IDX_MAX_W-1:0] idx);
        logic [N_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rtl/shared_reg_arbiter_rr_pick.sv - combinational circular priority encoder
//
// Ports:
//   eff_req  N      candidate request vector
//   rr_ptr   IDX_W  index where the search starts (must be < N)
//   winner   IDX_W  first set bit at or after rr_ptr, wrapping N-1 -> 0
//   any      1      at least one bit of eff_req is set
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     eff_req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    int idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            // rr_ptr < N and i < N, so a single subtraction keeps idx in range
            // even when N is not a power of two.
            idx = int'(rr_ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && eff_req[IDX_W'(idx)]) begin
                any    = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin write arbiter for one shared register
//
// Ports:
//   CLK      1           system clock, rising edge
//   n_Reset  1           synchronous active-low reset
//   req      N           write requests, one per requester
//   wdata    N*W         packed write data, requester i on [i*W +: W]
//   ack      N           one-hot, one cycle, registered grant acknowledge
//   Q        W           shared register contents
//   owner    clog2(N)    index of the last requester written
//   valid    1           set by the first write after reset
//   busy     1           high while the post-write hold window runs
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int HOLD = 2
) (
    input  logic                 CLK,
    input  logic                 n_Reset,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         ack,
    output logic [W-1:0]         Q,
    output logic [$clog2(N)-1:0] owner,
    output logic                 valid,
    output logic                 busy
);

    localparam int IDX_W = $clog2(N);

    state_e           state_q, state_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N-1:0]     ack_q, ack_d;
    logic [W-1:0]     q_q, q_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic [N-1:0]     eff_req;
    logic [IDX_W-1:0] winner;
    logic             any;
    logic [N_MAX-1:0] winner_oh;

    // A requester still high during its own ack cycle has not yet seen the ack.
    assign eff_req = req & ~ack_q;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .eff_req (eff_req),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner),
        .any     (any)
    );

    assign winner_oh = onehot(IDX_MAX_W'(winner));

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        ack_d      = '0;
        q_d        = q_q;
        owner_d    = owner_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    q_d      = wdata[int'(winner)*W +: W];
                    ack_d    = winner_oh[N-1:0];
                    owner_d  = winner;
                    valid_d  = 1'b1;
                    rr_ptr_d = (winner == IDX_W'(N-1)) ? '0 : winner + 1'b1;
                    if (HOLD > 0) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = 4'(HOLD);
                        busy_d     = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q - 4'd1;
                if (hold_cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!n_Reset) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rr_ptr_q   <= '0;
            ack_q      <= '0;
            q_q        <= '0;
            owner_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            ack_q      <= ack_d;
            q_q        <= q_d;
            owner_q    <= owner_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign ack   = ack_q;
    assign Q     = q_q;
    assign owner = owner_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - self-checking bench for shared_reg_arbiter
module tb_shared_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N*W-1:0] wdata;

    logic [N-1:0] ack0, ack1;
    logic [W-1:0] q0, q1;
    logic [1:0]   owner0, owner1;
    logic         valid0, valid1, busy0, busy1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shared_reg_arbiter #(.N(N), .W(W), .HOLD(2)) dut_h2 (
        .CLK(clk), .n_Reset(rst_n), .req(req), .wdata(wdata),
        .ack(ack0), .Q(q0), .owner(owner0), .valid(valid0), .busy(busy0)
    );

    shared_reg_arbiter #(.N(N), .W(W), .HOLD(0)) dut_h0 (
        .CLK(clk), .n_Reset(rst_n), .req(req), .wdata(wdata),
        .ack(ack1), .Q(q1), .owner(owner1), .valid(valid1), .busy(busy1)
    );

    // Reference model: one entry per instance. Writes are allowed once
    // HOLD+1 edges have passed since the previous write.
    int           m_hold [2] = '{2, 0};
    int           m_rr   [2];
    int           m_last [2];
    int           m_owner[2];
    int           m_q    [2];
    int           m_ack  [2];
    int           m_valid[2];
    int           edge_no = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    task automatic model_reset(input int k);
        m_rr[k] = 0; m_last[k] = -100; m_owner[k] = 0;
        m_q[k] = 0; m_ack[k] = 0; m_valid[k] = 0;
    endtask

    task automatic model_edge(input int k);
        int eff, w;
        if (!rst_n) begin
            model_reset(k);
            return;
        end
        eff = int'(req) & ~m_ack[k];
        w = -1;
        if (edge_no >= m_last[k] + m_hold[k] + 1) begin
            for (int j = 0; j < N; j++) begin
                if (w < 0 && eff[(m_rr[k] + j) % N]) w = (m_rr[k] + j) % N;
            end
        end
        if (w >= 0) begin
            m_q[k]     = int'(wdata[w*W +: W]);
            m_ack[k]   = 1 << w;
            m_owner[k] = w;
            m_valid[k] = 1;
            m_rr[k]    = (w + 1) % N;
            m_last[k]  = edge_no;
        end else begin
            m_ack[k] = 0;
        end
    endtask

    function automatic int m_busy(input int k);
        return (m_valid[k] != 0 && edge_no < m_last[k] + m_hold[k]) ? 1 : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        edge_no++;
        model_edge(0);
        model_edge(1);
        #1;
        check("h2_q",     int'(q0),     m_q[0]);
        check("h2_ack",   int'(ack0),   m_ack[0]);
        check("h2_owner", int'(owner0), m_owner[0]);
        check("h2_valid", int'(valid0), m_valid[0]);
        check("h2_busy",  int'(busy0),  m_busy(0));
        check("h0_q",     int'(q1),     m_q[1]);
        check("h0_ack",   int'(ack1),   m_ack[1]);
        check("h0_owner", int'(owner1), m_owner[1]);
        check("h0_valid", int'(valid1), m_valid[1]);
        check("h0_busy",  int'(busy1),  m_busy(1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        rst_n = 1'b0;
        req   = 4'b1111;
        wdata = 32'hDEADBEEF;

        // Reset held with all requests high: nothing written.
        step();
        step();
        check("rst_q", int'(q0), 0);
        check("rst_valid", int'(valid0), 0);
        check("rst_ack", int'(ack0), 0);

        // Single requester 2.
        rst_n = 1'b1;
        req   = 4'b0100;
        wdata = 32'h00A5_0000;
        step();
        check("single_q", int'(q0), 8'hA5);
        check("single_ack", int'(ack0), 4'b0100);
        check("single_owner", int'(owner0), 2);
        check("single_busy", int'(busy0), 1);
        req = 4'b0000;
        step();
        check("single_busy1", int'(busy0), 1);
        step();
        check("single_busy2", int'(busy0), 0);

        // Round-robin with all requesting.
        do_reset();
        req   = 4'b1111;
        wdata = 32'h1312_1110;
        for (int c = 1; c <= 13; c++) begin
            step();
            if (c % 3 == 1) check("rr_q", int'(q0), 8'h10 + ((c - 1) / 3) % 4);
        end

        // Wrap past idle slot 3.
        do_reset();
        req   = 4'b0100;
        wdata = 32'h4433_2211;
        step();
        req = 4'b0011;
        step();
        step();
        step();
        check("wrap_owner", int'(owner0), 0);
        step();
        step();
        step();
        check("wrap_next", int'(owner0), 1);

        // Back-to-back with HOLD=0, requester 1 held through its ack.
        do_reset();
        req = 4'b1010;
        step();
        check("b2b_first", int'(owner1), 1);
        step();
        check("b2b_second", int'(owner1), 3);
        check("b2b_ack", int'(ack1), 4'b1000);

        // Reset in the middle of the hold window.
        do_reset();
        req = 4'b0001;
        step();
        req   = 4'b0000;
        rst_n = 1'b0;
        step();
        check("midhold_busy", int'(busy0), 0);
        check("midhold_valid", int'(valid0), 0);
        check("midhold_q", int'(q0), 0);
        rst_n = 1'b1;
        req   = 4'b0010;
        step();
        check("midhold_owner", int'(owner0), 1);

        // Random traffic with occasional reset.
        for (int c = 0; c < 400; c++) begin
            req   = 4'($urandom);
            wdata = $urandom;
            rst_n = ($urandom_range(0, 39) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
